// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - width helpers and parameter legality check for the flagged FIFO
package fifo_pkg;

    // Pointer width: enough bits to index DEPTH entries.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width: must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Depth and both thresholds must sit inside their usable ranges.
    function automatic bit params_legal(input int depth, input int af, input int ae);
        return (depth >= 2) && (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH store, one write port, asynchronous read port
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store the accepted word; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, threshold flags, error pulses and FWFT option
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    // Refuse to build with out-of-range depth or thresholds.
    if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Flags come straight from the count register, no extra latency.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read frees a slot in the same cycle, so a full FIFO accepts write+read together.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (PTR_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr_q),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_q),
        .rd_data(mem_rdata)
    );

    // Next pointers, occupancy and rejected-request pulses.
    always_comb begin
        wr_ptr_d    = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        overflow_d  = wr_en & ~wr_acc;
        underflow_d = rd_en & ~rd_acc;
    end

    // Control state register; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is always on the output while anything is stored.
        assign rd_valid = ~empty;
        assign rd_data  = mem_rdata;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        // Capture the head on an accepted read; data holds otherwise.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = rd_acc;
            if (rd_acc) begin
                rd_data_d = mem_rdata;
            end
        end

        // Registered read port; reset discards any read in flight.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags in three configurations
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, wr_en, rd_en;
    logic [7:0] wr_data;

    logic [7:0] rdd [3];
    logic       rdv [3];
    logic       fu  [3];
    logic       em  [3];
    logic       afu [3];
    logic       aem [3];
    logic       ovf [3];
    logic       udf [3];
    logic [4:0] cnt0, cnt2;
    logic [2:0] cnt1;
    logic [4:0] cnt [3];

    assign cnt[0] = cnt0;
    assign cnt[1] = {2'b00, cnt1};
    assign cnt[2] = cnt2;

    // u0: registered read, depth 16; u1: registered read, depth 5; u2: FWFT, depth 16
    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[0]), .rd_valid(rdv[0]), .full(fu[0]), .empty(em[0]),
        .almost_full(afu[0]), .almost_empty(aem[0]), .count(cnt0),
        .overflow(ovf[0]), .underflow(udf[0]));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[1]), .rd_valid(rdv[1]), .full(fu[1]), .empty(em[1]),
        .almost_full(afu[1]), .almost_empty(aem[1]), .count(cnt1),
        .overflow(ovf[1]), .underflow(udf[1]));

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rdd[2]), .rd_valid(rdv[2]), .full(fu[2]), .empty(em[2]),
        .almost_full(afu[2]), .almost_empty(aem[2]), .count(cnt2),
        .overflow(ovf[2]), .underflow(udf[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a queue per instance plus the expected registered outputs.
    int         dep   [3] = '{16, 5, 16};
    int         af_t  [3] = '{14, 4, 14};
    int         ae_t  [3] = '{2, 1, 2};
    int         fwft  [3] = '{0, 0, 1};
    logic [7:0] mq    [3][$];
    logic [7:0] exp_rd[3];
    logic       exp_rv[3];
    logic       exp_ov[3];
    logic       exp_un[3];
    bit         model_ok = 0;

    // Compare on the falling edge, then advance the model with the inputs the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int  n;
                bit  racc, wacc;
                n = mq[i].size();
                if (model_ok) begin
                    chk($sformatf("u%0d count", i),        32'(cnt[i]), 32'(n));
                    chk($sformatf("u%0d full", i),         32'(fu[i]),  32'(n == dep[i]));
                    chk($sformatf("u%0d empty", i),        32'(em[i]),  32'(n == 0));
                    chk($sformatf("u%0d almost_full", i),  32'(afu[i]), 32'(n >= af_t[i]));
                    chk($sformatf("u%0d almost_empty", i), 32'(aem[i]), 32'(n <= ae_t[i]));
                    chk($sformatf("u%0d overflow", i),     32'(ovf[i]), 32'(exp_ov[i]));
                    chk($sformatf("u%0d underflow", i),    32'(udf[i]), 32'(exp_un[i]));
                    if (fwft[i] != 0) begin
                        chk($sformatf("u%0d rd_valid", i), 32'(rdv[i]), 32'(n != 0));
                        if (n != 0) chk($sformatf("u%0d rd_data", i), 32'(rdd[i]), 32'(mq[i][0]));
                    end else begin
                        chk($sformatf("u%0d rd_valid", i), 32'(rdv[i]), 32'(exp_rv[i]));
                        chk($sformatf("u%0d rd_data", i),  32'(rdd[i]), 32'(exp_rd[i]));
                    end
                end
                if (reset) begin
                    mq[i].delete();
                    exp_rd[i] = 8'h00;
                    exp_rv[i] = 1'b0;
                    exp_ov[i] = 1'b0;
                    exp_un[i] = 1'b0;
                end else begin
                    racc      = rd_en && (n > 0);
                    wacc      = wr_en && ((n < dep[i]) || racc);
                    exp_ov[i] = wr_en && !wacc;
                    exp_un[i] = rd_en && !racc;
                    exp_rv[i] = racc;
                    if (racc) exp_rd[i] = mq[i].pop_front();
                    if (wacc) mq[i].push_back(wr_data);
                end
            end
            model_ok = 1;
        end
    end

    task automatic step(input logic rst, input logic w, input logic [7:0] d, input logic r);
        reset   = rst;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("reset count",        32'(cnt0),   32'd0);
        chk("reset empty",        32'(em[0]),  32'd1);
        chk("reset almost_empty", 32'(aem[0]), 32'd1);
        chk("reset full",         32'(fu[0]),  32'd0);
        chk("reset rd_valid",     32'(rdv[0]), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(i + 1), 0);
            chk("fill almost_full", 32'(afu[0]), 32'((i + 1) >= 14));
            chk("fill full",        32'(fu[0]),  32'(i == 15));
        end
        chk("fill count", 32'(cnt0), 32'd16);

        step(0, 1, 8'hEE, 0);
        chk("overflow pulse", 32'(ovf[0]), 32'd1);
        chk("overflow count", 32'(cnt0),   32'd16);
        step(0, 0, 8'h00, 0);
        chk("overflow clears", 32'(ovf[0]), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(0, 0, 8'h00, 1);
            chk("drain rd_data",  32'(rdd[0]), 32'(i + 1));
            chk("drain rd_valid", 32'(rdv[0]), 32'd1);
        end
        chk("drained empty", 32'(em[0]), 32'd1);
        step(0, 0, 8'h00, 1);
        chk("underflow pulse", 32'(udf[0]), 32'd1);
        chk("underflow no valid", 32'(rdv[0]), 32'd0);

        for (int i = 0; i < 16; i++) step(0, 1, 8'(8'h31 + i), 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'(8'h80 + i), 1);
            chk("full rw rd_data",  32'(rdd[0]), 32'(8'h31 + i));
            chk("full rw count",    32'(cnt0),   32'd16);
            chk("full rw overflow", 32'(ovf[0]), 32'd0);
        end
        for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1);

        for (int i = 0; i < 20; i++) step(0, (i % 3) != 2, 8'(8'h50 + i), (i % 2) == 1);
        for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 1);

        step(0, 1, 8'hA5, 0);
        chk("fwft rd_valid", 32'(rdv[2]), 32'd1);
        chk("fwft rd_data",  32'(rdd[2]), 32'hA5);
        chk("reg no valid",  32'(rdv[0]), 32'd0);
        step(0, 0, 8'h00, 1);
        chk("fwft pop valid", 32'(rdv[2]), 32'd0);
        chk("reg rd_data A5", 32'(rdd[0]), 32'hA5);

        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h61 + i), 0);
        chk("burst count", 32'(cnt0), 32'd7);
        step(1, 1, 8'h77, 1);
        chk("mid reset count",        32'(cnt0),   32'd0);
        chk("mid reset empty",        32'(em[0]),  32'd1);
        chk("mid reset rd_valid",     32'(rdv[0]), 32'd0);
        chk("mid reset almost_empty", 32'(aem[0]), 32'd1);
        chk("mid reset d5 count",     32'(cnt[1]), 32'd0);
        chk("mid reset fwft valid",   32'(rdv[2]), 32'd0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
